// File: rtl/pseudo_linear_train_ctrl.sv
// Training/evaluation sequencer for the ten one-vs-rest pseudo-linear learners.
// Fetches samples, gates learner updates during training, then scores one evaluation pass.
module pseudo_linear_train_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int N_CLASS = 10,
  parameter int PIX     = 784,
  parameter int SETTLE  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   num_samples,
  input  logic [7:0]          num_epochs,
  input  logic [3:0]          threshold_cfg,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_valid,
  input  logic [PIX+9:0]      mem_data,
  output logic [PIX+9:0]      image_data,
  output logic [3:0]          threshold,
  output logic                upd_en,
  input  logic [N_CLASS-1:0]  result_vec,
  output logic                busy,
  output logic                done,
  output logic [7:0]          epoch,
  output logic [ADDR_W-1:0]   correct_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SETTLE,
    S_UPDATE,
    S_SCORE,
    S_ADVANCE,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t              state_reg;
  logic [ADDR_W-1:0]   ns_reg;
  logic [7:0]          ne_reg;
  logic                eval_reg;
  logic [3:0]          settle_reg;

  logic                last_sample;
  logic                label_match;
  logic [7:0]          epoch_inc;

  // mem_addr doubles as the sample address register.
  assign last_sample = (mem_addr == ns_reg - ADDR_W'(1));
  assign label_match = (result_vec == image_data[N_CLASS-1:0]);
  assign epoch_inc   = epoch + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      ns_reg      <= '0;
      ne_reg      <= '0;
      eval_reg    <= 1'b0;
      settle_reg  <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      image_data  <= '0;
      threshold   <= '0;
      upd_en      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      epoch       <= '0;
      correct_cnt <= '0;
    end else begin
      done   <= 1'b0;
      upd_en <= 1'b0;
      if (state_reg != S_IDLE && abort) begin
        // Counters and image keep their values so the aborted run can be inspected.
        state_reg <= S_IDLE;
        mem_req   <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (start && !abort) begin
              ns_reg      <= num_samples;
              ne_reg      <= num_epochs;
              threshold   <= threshold_cfg;
              eval_reg    <= (num_epochs == 8'd0);
              epoch       <= '0;
              mem_addr    <= '0;
              correct_cnt <= '0;
              busy        <= 1'b1;
              if (num_samples == '0) begin
                state_reg <= S_DONE;
              end else begin
                state_reg <= S_FETCH;
                mem_req   <= 1'b1;
              end
            end
          end

          S_FETCH: begin
            if (mem_valid) begin
              image_data <= mem_data;
              mem_req    <= 1'b0;
              settle_reg <= SETTLE_LAST;
              state_reg  <= S_SETTLE;
            end
          end

          S_SETTLE: begin
            if (settle_reg == 4'd0) begin
              if (eval_reg) begin
                state_reg <= S_SCORE;
              end else begin
                state_reg <= S_UPDATE;
                upd_en    <= 1'b1;
              end
            end else begin
              settle_reg <= settle_reg - 4'd1;
            end
          end

          S_UPDATE: begin
            state_reg <= S_ADVANCE;
          end

          S_SCORE: begin
            if (label_match && (correct_cnt != '1)) begin
              correct_cnt <= correct_cnt + ADDR_W'(1);
            end
            state_reg <= S_ADVANCE;
          end

          S_ADVANCE: begin
            if (!last_sample) begin
              mem_addr  <= mem_addr + ADDR_W'(1);
              state_reg <= S_FETCH;
              mem_req   <= 1'b1;
            end else begin
              mem_addr <= '0;
              if (!eval_reg) begin
                epoch <= epoch_inc;
                if (epoch_inc == ne_reg) begin
                  eval_reg <= 1'b1;
                end
                state_reg <= S_FETCH;
                mem_req   <= 1'b1;
              end else begin
                state_reg <= S_DONE;
              end
            end
          end

          S_DONE: begin
            state_reg <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end

          default: begin
            state_reg <= S_IDLE;
            mem_req   <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pseudo_linear_train_ctrl.sv
// Bench for pseudo_linear_train_ctrl: vector table, randomized runs against a run-level model,
// and directed abort/reset/zero-sample sequences.
module tb_pseudo_linear_train_ctrl;
  localparam int ADDR_W  = 16;
  localparam int N_CLASS = 10;
  localparam int PIX     = 784;
  localparam int SETTLE  = 1;
  localparam int W       = PIX + 10;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               abort;
  logic [ADDR_W-1:0]  num_samples;
  logic [7:0]         num_epochs;
  logic [3:0]         threshold_cfg;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_valid;
  logic [W-1:0]       mem_data;
  logic [W-1:0]       image_data;
  logic [3:0]         threshold;
  logic               upd_en;
  logic [N_CLASS-1:0] result_vec;
  logic               busy;
  logic               done;
  logic [7:0]         epoch;
  logic [ADDR_W-1:0]  correct_cnt;

  pseudo_linear_train_ctrl #(
    .ADDR_W(ADDR_W), .N_CLASS(N_CLASS), .PIX(PIX), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_samples(num_samples), .num_epochs(num_epochs), .threshold_cfg(threshold_cfg),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
    .image_data(image_data), .threshold(threshold), .upd_en(upd_en),
    .result_vec(result_vec), .busy(busy), .done(done), .epoch(epoch),
    .correct_cnt(correct_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Sample memory contents and the result each learner bank reports for that sample.
  logic [9:0] mem_lab [64];
  logic [9:0] mem_res [64];

  int  mem_lat  = 2;
  bit  mem_auto = 1'b1;
  bit  pending  = 1'b0;
  int  lat_cnt  = 0;

  int  upd_cnt, fetch_cnt, done_cnt, addr_err, order_err;
  int  cur_ns, cur_ne;
  logic prev_req = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] word(input logic [ADDR_W-1:0] a);
    logic [W-1:0] w;
    w = '0;
    w[9:0]        = mem_lab[a[5:0]];
    w[25:10]      = a;
    w[W-1 -: 16]  = ~a;
    return w;
  endfunction

  // Memory responder: mem_valid mem_lat cycles after a request is first seen.
  initial begin
    mem_valid = 1'b0;
    mem_data  = '0;
    forever begin
      @(negedge clk);
      if (mem_auto) begin
        if (mem_valid) begin
          mem_valid = 1'b0;
        end else if (mem_req) begin
          if (!pending) begin
            pending = 1'b1;
            lat_cnt = mem_lat;
          end
          if (lat_cnt == 0) begin
            mem_valid = 1'b1;
            mem_data  = word(mem_addr);
            pending   = 1'b0;
          end else begin
            lat_cnt--;
          end
        end else begin
          pending = 1'b0;
        end
      end
    end
  end

  // Learner stand-in: result depends on which sample is currently presented.
  initial begin
    result_vec = '0;
    forever begin
      @(negedge clk);
      result_vec = mem_res[image_data[15:10]];
    end
  end

  // Run monitor: fetch address sequence, update pulses and done pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        if (cur_ns > 0 && mem_addr != ADDR_W'(fetch_cnt % cur_ns)) addr_err++;
        fetch_cnt++;
      end
      prev_req = mem_req;
      if (upd_en) begin
        upd_cnt++;
        if (fetch_cnt > cur_ns * cur_ne) order_err++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic run_case(input string name, input int ns, input int ne, input int thr,
                          input int e_upd, input int e_fetch, input int e_corr, input int e_epoch);
    int b;
    @(negedge clk);
    upd_cnt = 0; fetch_cnt = 0; done_cnt = 0; addr_err = 0; order_err = 0;
    cur_ns = ns; cur_ne = ne;
    num_samples   = ADDR_W'(ns);
    num_epochs    = 8'(ne);
    threshold_cfg = 4'(thr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    b = 0;
    while (done_cnt == 0 && b < 20000) begin
      @(negedge clk);
      b++;
    end
    repeat (3) @(negedge clk);
    $display("run %s ns=%0d ne=%0d: upd=%0d fetch=%0d correct=%0d epoch=%0d done=%0d",
             name, ns, ne, upd_cnt, fetch_cnt, correct_cnt, epoch, done_cnt);
    check({name, ".done_cnt"}, done_cnt, 1);
    check({name, ".upd_cnt"}, upd_cnt, e_upd);
    check({name, ".fetch_cnt"}, fetch_cnt, e_fetch);
    check({name, ".addr_seq_err"}, addr_err, 0);
    check({name, ".upd_in_eval"}, order_err, 0);
    check({name, ".correct_cnt"}, correct_cnt, e_corr);
    check({name, ".epoch"}, epoch, e_epoch);
    check({name, ".threshold"}, threshold, thr);
    check({name, ".busy_after"}, busy, 0);
  endtask

  typedef struct {
    int ns;
    int ne;
    int thr;
    logic [3:0][9:0] lab;
    logic [3:0][9:0] res;
    int e_upd;
    int e_fetch;
    int e_corr;
    int e_epoch;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [W-1:0] saved;
    int b;

    vecs[0] = '{3, 2, 5, {10'h000, 10'h200, 10'h002, 10'h010},
                         {10'h000, 10'h200, 10'h003, 10'h010}, 6, 9, 2, 2};
    vecs[1] = '{0, 5, 3, {10'h000, 10'h000, 10'h000, 10'h000},
                         {10'h000, 10'h000, 10'h000, 10'h000}, 0, 0, 0, 0};
    vecs[2] = '{4, 0, 9, {10'h008, 10'h004, 10'h002, 10'h001},
                         {10'h008, 10'h004, 10'h000, 10'h001}, 0, 4, 3, 0};
    vecs[3] = '{1, 1, 15, {10'h000, 10'h000, 10'h000, 10'h080},
                          {10'h000, 10'h000, 10'h000, 10'h080}, 1, 2, 1, 1};
    for (int i = 0; i < 64; i++) begin
      mem_lab[i] = '0;
      mem_res[i] = '0;
    end

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    num_samples = '0; num_epochs = '0; threshold_cfg = '0;
    repeat (3) @(negedge clk);
    check("reset.outputs", {busy, mem_req, upd_en, done, epoch, correct_cnt, mem_addr, threshold}, 0);
    check("reset.image", image_data == '0, 1);
    rst = 1'b0;

    // Vector table.
    mem_lat = 2;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        mem_lab[j] = vecs[i].lab[j];
        mem_res[j] = vecs[i].res[j];
      end
      run_case($sformatf("vec%0d", i), vecs[i].ns, vecs[i].ne, vecs[i].thr,
               vecs[i].e_upd, vecs[i].e_fetch, vecs[i].e_corr, vecs[i].e_epoch);
    end

    // Randomized runs; expected totals follow from the run rules directly.
    for (int r = 0; r < 5; r++) begin
      int ns, ne, thr, corr;
      ns  = $urandom_range(1, 12);
      ne  = $urandom_range(0, 3);
      thr = $urandom_range(0, 15);
      mem_lat = $urandom_range(0, 3);
      corr = 0;
      for (int j = 0; j < ns; j++) begin
        mem_lab[j] = 10'(1 << $urandom_range(0, 9));
        mem_res[j] = $urandom_range(0, 1) ? mem_lab[j] : 10'($urandom_range(0, 1023));
        if (mem_res[j] == mem_lab[j]) corr++;
      end
      run_case($sformatf("rand%0d", r), ns, ne, thr, ns * ne, ns * (ne + 1), corr, ne);
    end

    // Zero samples: done two edges after start is sampled.
    mem_lat = 2;
    @(negedge clk);
    num_samples = '0; num_epochs = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero.done_early", done, 0);
    check("zero.busy", busy, 1);
    @(negedge clk);
    check("zero.done_pulse", done, 1);
    check("zero.mem_req", mem_req, 0);
    @(negedge clk);
    check("zero.done_once", done, 0);

    // Start and abort together in IDLE.
    num_samples = 16'd2;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("idle_abort.busy", busy, 0);
    $display("seq idle start+abort: busy=%0b", busy);

    // Abort in FETCH with mem_valid in the same cycle.
    mem_auto = 1'b0;
    num_samples = 16'd3; num_epochs = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort.req_pre", mem_req, 1);
    saved = image_data;
    b = done_cnt;
    abort = 1'b1; mem_valid = 1'b1; mem_data = '1;
    @(negedge clk);
    abort = 1'b0; mem_valid = 1'b0;
    check("abort.busy", busy, 0);
    check("abort.mem_req", mem_req, 0);
    check("abort.image_hold", image_data == saved, 1);
    repeat (3) @(negedge clk);
    check("abort.no_done", done_cnt, b);
    $display("seq abort in fetch: busy=%0b mem_req=%0b", busy, mem_req);
    pending = 1'b0;
    mem_auto = 1'b1;
    for (int j = 0; j < 4; j++) begin
      mem_lab[j] = vecs[0].lab[j];
      mem_res[j] = vecs[0].res[j];
    end
    run_case("rerun", 3, 1, 7, 3, 6, 2, 1);

    // start held high; reset during UPDATE.
    mem_lat = 1;
    num_samples = 16'd2; num_epochs = 8'd2; threshold_cfg = 4'd6;
    start = 1'b1;
    b = 0;
    while (!upd_en && b < 2000) begin
      @(negedge clk);
      b++;
    end
    check("rst.upd_seen", upd_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst.outputs", {busy, mem_req, upd_en, done, epoch, correct_cnt, mem_addr, threshold}, 0);
    check("rst.image", image_data == '0, 1);
    @(negedge clk);
    check("rst.restart", busy, 1);
    b = 0;
    while (!done && b < 2000) begin
      @(negedge clk);
      b++;
    end
    check("held.done", done, 1);
    check("held.idle_busy", busy, 0);
    @(negedge clk);
    check("held.rerun_busy", busy, 1);
    $display("seq start held + rst: epoch=%0d correct=%0d", epoch, correct_cnt);
    abort = 1'b1; start = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    check("held.abort_busy", busy, 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
